// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared state encoding, op encoding and wait-counter width for mem_ctrl.
// Revision : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam int WAIT_W = 4;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] ACCESS  = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_cnt
// Brief    : Load / decrement down-counter with zero flag, used for the ACCESS dwell.
// Revision : 1.0
// ============================================================================
module mem_wait_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : MAR/MDR owner and RAM strobe sequencer (SETUP/ACCESS/CAPTURE|RELEASE/DONE).
// Revision : 1.0
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              start_rd,
    input  logic              start_wr,
    input  logic [DATA_W-1:0] Mdatain,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] MDRout_data,
    output logic              busy,
    output logic              done,
    output logic              protocol_err
);

    localparam logic [WAIT_W-1:0] c_wait_load = WAIT_W'(WAIT_CYCLES);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_op;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_read;
    logic              r_write;
    logic              r_busy;
    logic              r_done;
    logic              r_perr;
    logic              w_start_one;
    logic              w_wait_zero;
    logic [WAIT_W-1:0] w_wait_count;

    assign w_start_one = start_rd ^ start_wr;

    mem_wait_cnt #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .clr        (clr),
        .i_load     (r_state == SETUP),
        .i_load_val (c_wait_load),
        .i_dec      (r_state == ACCESS),
        .o_count    (w_wait_count),
        .o_zero     (w_wait_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_one) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_wait_zero) w_next = (r_op == OP_RD) ? CAPTURE : RELEASE;
            CAPTURE: w_next = DONE;
            RELEASE: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes and flags are decoded from the next state so they are registered yet align with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                if (MARin)       r_mar <= BusMuxOut[ADDR_W-1:0];
                if (MDRin)       r_mdr <= BusMuxOut;
                if (w_start_one) r_op  <= start_wr ? OP_WR : OP_RD;
                r_perr <= start_rd & start_wr;
            end else begin
                r_perr <= start_rd | start_wr;
            end
            if (r_state == CAPTURE) r_mdr <= Mdatain;
            r_read  <= ((w_next == ACCESS) && (r_op == OP_RD)) || (w_next == CAPTURE);
            r_write <= (w_next == ACCESS) && (r_op == OP_WR);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    assign address      = r_mar;
    assign mem_wdata    = r_mdr;
    assign MDRout_data  = r_mdr;
    assign read         = r_read;
    assign write        = r_write;
    assign busy         = r_busy;
    assign done         = r_done;
    assign protocol_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench: three mem_ctrl instances (WAIT_CYCLES 1, 0, 15) on RAM models.
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;

    logic [31:0] bus  [3];
    logic        marin[3];
    logic        mdrin[3];
    logic        srd  [3];
    logic        swr  [3];
    logic [31:0] mdat [3];
    logic [8:0]  addr [3];
    logic [31:0] wdat [3];
    logic [31:0] mdro [3];
    logic        rd   [3];
    logic        wr   [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic        perr [3];

    logic [31:0] ram     [3][512];
    logic [31:0] ref_mem [3][512];

    logic        pl_en   = 1'b0;
    int          pl_sel  = 0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic int wc(input int sel);
        return (sel == 0) ? 1 : ((sel == 1) ? 0 : 15);
    endfunction

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_dut
            mem_ctrl #(
                .ADDR_W      (9),
                .DATA_W      (32),
                .WAIT_CYCLES ((k == 0) ? 1 : ((k == 1) ? 0 : 15))
            ) u_dut (
                .clk          (clk),
                .clr          (clr),
                .BusMuxOut    (bus[k]),
                .MARin        (marin[k]),
                .MDRin        (mdrin[k]),
                .start_rd     (srd[k]),
                .start_wr     (swr[k]),
                .Mdatain      (mdat[k]),
                .address      (addr[k]),
                .mem_wdata    (wdat[k]),
                .read         (rd[k]),
                .write        (wr[k]),
                .MDRout_data  (mdro[k]),
                .busy         (bsy[k]),
                .done         (dn[k]),
                .protocol_err (perr[k])
            );
            assign mdat[k] = ram[k][addr[k]];
        end
    endgenerate

    // RAM models: level-sensitive write strobe sampled each edge, plus a bench preload port.
    always @(posedge clk) begin
        if (pl_en) ram[pl_sel][pl_addr] <= pl_data;
        for (int m = 0; m < 3; m++) begin
            if (wr[m]) ram[m][addr[m]] <= wdat[m];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int sel, input logic [8:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
        ref_mem[sel][a] = d;
    endtask

    // One complete access; expectations come from latency/strobe rules and the reference memory.
    task automatic access(input int sel, input bit is_wr, input logic [8:0] a, input logic [31:0] d);
        int n, strobe_cycles;
        bit addr_ok, overlap;
        n = 0; strobe_cycles = 0; addr_ok = 1'b1; overlap = 1'b0;
        if (is_wr) begin
            bus[sel] = d; mdrin[sel] = 1'b1;
            tick();
            mdrin[sel] = 1'b0;
        end
        bus[sel] = {23'd0, a}; marin[sel] = 1'b1;
        srd[sel] = !is_wr; swr[sel] = is_wr;
        tick();
        marin[sel] = 1'b0; srd[sel] = 1'b0; swr[sel] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (is_wr ? wr[sel] : rd[sel]) strobe_cycles++;
            if (addr[sel] !== a) addr_ok = 1'b0;
            if (rd[sel] && wr[sel]) overlap = 1'b1;
            if (dn[sel]) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== wc(sel) + 3) $display("FAIL latency inst%0d: got %0d edges, want %0d", sel, n, wc(sel) + 3);
        else passed++;
        checks++;
        if (strobe_cycles !== (is_wr ? wc(sel) + 1 : wc(sel) + 2))
            $display("FAIL strobe_len inst%0d wr=%0d: got %0d, want %0d", sel, is_wr, strobe_cycles,
                     is_wr ? wc(sel) + 1 : wc(sel) + 2);
        else passed++;
        checks++;
        if (!addr_ok || overlap) $display("FAIL addr_hold inst%0d: addr_ok=%0d overlap=%0d, want 1/0", sel, addr_ok, overlap);
        else passed++;
        if (is_wr) begin
            ref_mem[sel][a] = d;
        end else begin
            checks++;
            if (mdro[sel] !== ref_mem[sel][a])
                $display("FAIL read_data inst%0d @%h: got %h, want %h", sel, a, mdro[sel], ref_mem[sel][a]);
            else passed++;
        end
        tick();
        checks++;
        if (bsy[sel] !== 1'b0 || dn[sel] !== 1'b0) $display("FAIL idle_after inst%0d: busy=%b done=%b, want 0/0", sel, bsy[sel], dn[sel]);
        else passed++;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({rd[s], wr[s], bsy[s], dn[s], perr[s], addr[s], mdro[s]} !== '0)
                $display("FAIL reset inst%0d: rd=%b wr=%b busy=%b done=%b perr=%b addr=%h mdr=%h, want all 0",
                         s, rd[s], wr[s], bsy[s], dn[s], perr[s], addr[s], mdro[s]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [8:0]  a;
        logic [31:0] old_word;
        a = 9'h0A5;
        old_word = ref_mem[0][a];
        bus[0] = ~old_word; mdrin[0] = 1'b1;
        tick();
        mdrin[0] = 1'b0;
        bus[0] = {23'd0, a}; marin[0] = 1'b1; swr[0] = 1'b1;
        tick();
        marin[0] = 1'b0; swr[0] = 1'b0;
        tick();
        checks++;
        if (wr[0] !== 1'b1) $display("FAIL midwr_strobe: write=%b, want 1", wr[0]);
        else passed++;
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({wr[0], bsy[0], addr[0], mdro[0]} !== '0)
            $display("FAIL async_reset: write=%b busy=%b addr=%h mdr=%h, want all 0", wr[0], bsy[0], addr[0], mdro[0]);
        else passed++;
        tick(); tick();
        clr = 1'b0;
        tick(); tick();
        checks++;
        if (ram[0][a] !== old_word) $display("FAIL ram_untouched: got %h, want %h", ram[0][a], old_word);
        else passed++;
    endtask

    task automatic test_directed_rw();
        preload(0, 9'h012, 32'hDEAD_BEEF);
        access(0, 1'b0, 9'h012, 32'h0);
        checks++;
        if (mdro[0] !== 32'hDEAD_BEEF) $display("FAIL read_12: got %h, want deadbeef", mdro[0]);
        else passed++;
        access(0, 1'b1, 9'h1FF, 32'hCAFE_0001);
        access(0, 1'b0, 9'h1FF, 32'h0);
        checks++;
        if (mdro[0] !== 32'hCAFE_0001) $display("FAIL readback_1ff: got %h, want cafe0001", mdro[0]);
        else passed++;
    endtask

    task automatic test_both_starts();
        srd[0] = 1'b1; swr[0] = 1'b1;
        tick();
        srd[0] = 1'b0; swr[0] = 1'b0;
        checks++;
        if (perr[0] !== 1'b1 || bsy[0] !== 1'b0 || rd[0] !== 1'b0 || wr[0] !== 1'b0)
            $display("FAIL both_starts: perr=%b busy=%b rd=%b wr=%b, want 1/0/0/0", perr[0], bsy[0], rd[0], wr[0]);
        else passed++;
        tick();
        checks++;
        if (perr[0] !== 1'b0 || bsy[0] !== 1'b0) $display("FAIL both_starts_after: perr=%b busy=%b, want 0/0", perr[0], bsy[0]);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        logic [8:0]  a;
        int n;
        a = 9'h0C3;
        n = 0;
        preload(0, a, 32'h1234_ABCD);
        bus[0] = {23'd0, a}; marin[0] = 1'b1; srd[0] = 1'b1;
        tick();
        marin[0] = 1'b0; srd[0] = 1'b0;
        tick();
        bus[0] = 32'h5555_5555; marin[0] = 1'b1; mdrin[0] = 1'b1; swr[0] = 1'b1;
        tick();
        marin[0] = 1'b0; mdrin[0] = 1'b0; swr[0] = 1'b0;
        checks++;
        if (perr[0] !== 1'b1 || addr[0] !== a)
            $display("FAIL busy_ignore: perr=%b addr=%h, want 1/%h", perr[0], addr[0], a);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dn[0]) begin
                n = i + 1;
                break;
            end
        end
        checks++;
        if (n == 0 || mdro[0] !== 32'h1234_ABCD || wr[0] !== 1'b0)
            $display("FAIL busy_read_done: done_seen=%0d mdr=%h, want 1/1234abcd", n != 0, mdro[0]);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back(input int sel);
        int n;
        n = 0;
        preload(sel, 9'h000, $urandom);
        preload(sel, 9'h001, $urandom);
        access(sel, 1'b0, 9'h000, 32'h0);
        access(sel, 1'b0, 9'h001, 32'h0);
        // A start issued while done is high must be refused.
        bus[sel] = 32'h0; marin[sel] = 1'b1; srd[sel] = 1'b1;
        tick();
        marin[sel] = 1'b0; srd[sel] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dn[sel]) begin
                n = 1;
                break;
            end
        end
        srd[sel] = 1'b1;
        tick();
        srd[sel] = 1'b0;
        checks++;
        if (n != 1 || perr[sel] !== 1'b1) $display("FAIL done_cycle_start inst%0d: done_seen=%0d perr=%b, want 1/1", sel, n, perr[sel]);
        else passed++;
        tick();
        checks++;
        if (bsy[sel] !== 1'b0) $display("FAIL done_cycle_accepted inst%0d: busy=%b, want 0", sel, bsy[sel]);
        else passed++;
    endtask

    task automatic test_random(input int sel, input int iters);
        for (int i = 0; i < iters; i++) begin
            access(sel, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            bus[s] = '0; marin[s] = 1'b0; mdrin[s] = 1'b0; srd[s] = 1'b0; swr[s] = 1'b0;
        end
        #1;
        test_reset();
        tick(); tick();
        clr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int a = 0; a < 512; a++) preload(s, 9'(a), $urandom);
        end
        test_reset_mid_write();
        test_directed_rw();
        test_both_starts();
        test_busy_ignore();
        test_back_to_back(1);
        test_back_to_back(2);
        test_random(0, 20);
        test_random(1, 20);
        test_random(2, 10);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
